// File: rtl/binary_counter.sv
// Loadable up-counter with synchronous reset, terminal-count compare and a
// registered one-cycle wrap pulse on all-ones to zero rollover.
module binary_counter #(
    parameter int unsigned            WIDTH       = 8,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // Priority per edge: reset, then load, then enable, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_VALUE;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= data;
            wrap  <= 1'b0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
            wrap  <= &count;
        end else begin
            wrap  <= 1'b0;
        end
    end

    always_comb begin
        tc = &count;
    end

endmodule

// File: tb/tb_binary_counter.sv
// Directed-vector bench for binary_counter (WIDTH=8, RESET_VALUE=0) with
// hand-computed expected count, tc and wrap after every clock edge.
module tb_binary_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       load;
    logic [7:0] data;
    logic [7:0] count;
    logic       tc;
    logic       wrap;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    binary_counter #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .load   (load),
        .data   (data),
        .count  (count),
        .tc     (tc),
        .wrap   (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 ns later and compare.
    task automatic step(input string tag, input logic r, input logic l, input logic e,
                        input logic [7:0] d, input logic [7:0] exp_count,
                        input logic exp_tc, input logic exp_wrap);
        reset  = r;
        load   = l;
        enable = e;
        data   = d;
        @(posedge clk);
        #1;
        check({tag, ".count"}, 32'(count), 32'(exp_count));
        check({tag, ".tc"},    32'(tc),    32'(exp_tc));
        check({tag, ".wrap"},  32'(wrap),  32'(exp_wrap));
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; enable = 1'b0; data = 8'h00;

        // Reset for two edges (5, 15 ns), then one idle edge at 25 ns.
        step("rst0", 1, 0, 0, 8'h00, 8'h00, 0, 0);
        step("rst1", 1, 0, 0, 8'h00, 8'h00, 0, 0);
        step("idle", 0, 0, 0, 8'h00, 8'h00, 0, 0);

        // Count 01..05 on edges 35..75 ns.
        step("cnt1", 0, 0, 1, 8'h00, 8'h01, 0, 0);
        step("cnt2", 0, 0, 1, 8'h00, 8'h02, 0, 0);
        step("cnt3", 0, 0, 1, 8'h00, 8'h03, 0, 0);
        step("cnt4", 0, 0, 1, 8'h00, 8'h04, 0, 0);
        step("cnt5", 0, 0, 1, 8'h00, 8'h05, 0, 0);

        // Hold with enable low.
        for (int i = 0; i < 3; i++)
            step("hold", 0, 0, 0, 8'h00, 8'h05, 0, 0);

        // Load A5, hold, then count to AA.
        step("ldA5",  0, 1, 0, 8'hA5, 8'hA5, 0, 0);
        step("hldA5", 0, 0, 0, 8'h00, 8'hA5, 0, 0);
        step("cntA6", 0, 0, 1, 8'h00, 8'hA6, 0, 0);
        step("cntA7", 0, 0, 1, 8'h00, 8'hA7, 0, 0);
        step("cntA8", 0, 0, 1, 8'h00, 8'hA8, 0, 0);
        step("cntA9", 0, 0, 1, 8'h00, 8'hA9, 0, 0);
        step("cntAA", 0, 0, 1, 8'h00, 8'hAA, 0, 0);

        // Reset mid-count while enable stays high.
        step("midrst0", 1, 0, 1, 8'h00, 8'h00, 0, 0);
        step("midrst1", 1, 0, 1, 8'h00, 8'h00, 0, 0);

        // Wrap: FE -> FF (tc) -> 00 (wrap) -> 01.
        step("ldFE",  0, 1, 0, 8'hFE, 8'hFE, 0, 0);
        step("wFF",   0, 0, 1, 8'h00, 8'hFF, 1, 0);
        step("w00",   0, 0, 1, 8'h00, 8'h00, 0, 1);
        step("w01",   0, 0, 1, 8'h00, 8'h01, 0, 0);

        // Loading all-ones raises tc without a wrap pulse; holding keeps wrap low.
        step("ldFF",   0, 1, 0, 8'hFF, 8'hFF, 1, 0);
        step("hldFF",  0, 0, 0, 8'h00, 8'hFF, 1, 0);
        step("w2_00",  0, 0, 1, 8'h00, 8'h00, 0, 1);

        // Load from all-ones with enable high must not pulse wrap.
        step("ldFF2",  0, 1, 0, 8'hFF, 8'hFF, 1, 0);
        step("ldEn05", 0, 1, 1, 8'h05, 8'h05, 0, 0);

        // Priority: load over enable, reset over everything.
        step("ldEn3C",   0, 1, 1, 8'h3C, 8'h3C, 0, 0);
        step("rstLdEn",  1, 1, 1, 8'h3C, 8'h00, 0, 0);
        step("postrst",  0, 0, 1, 8'h00, 8'h01, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
